// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the UART boot loader: protocol and receiver
// state encodings plus the frame sync byte.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        P_WAIT_SYNC,
        P_LEN_LO,
        P_LEN_HI,
        P_DATA,
        P_CSUM,
        P_DONE,
        P_ERROR
    } proto_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizes the raw pin, times each bit from the
// start-bit edge and reports a good byte or a framing error as one-cycle pulses.
module uart_rx_byte
    import boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT + 1);

    rx_state_t   r_state;
    rx_state_t   w_state_next;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_valid;
    logic        r_ferr;
    logic        w_half_tick;
    logic        w_bit_tick;

    assign w_half_tick = (r_cnt == CW'(HALF_BIT - 1));
    assign w_bit_tick  = (r_cnt == CW'(CLKS_PER_BIT - 1));

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_state_next = RX_START;
            RX_START: if (w_half_tick) w_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_tick && r_bit == 3'd7) w_state_next = RX_STOP;
            RX_STOP:  if (w_bit_tick) w_state_next = RX_IDLE;
            default:  w_state_next = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_state   <= w_state_next;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;

            // Counter restarts on every state change and every full bit period.
            if (r_state != w_state_next || w_bit_tick)
                r_cnt <= '0;
            else if (r_state != RX_IDLE)
                r_cnt <= r_cnt + CW'(1);

            case (r_state)
                RX_START: r_bit <= '0;
                RX_DATA: begin
                    if (w_bit_tick) begin
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (w_bit_tick) begin
                        r_valid <= r_rx_sync;
                        r_ferr  <= !r_rx_sync;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_o       = r_shift;
    assign byte_valid_o = r_valid;
    assign frame_err_o  = r_ferr;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: parses A5/LEN/data/CSUM frames from the UART, writes the
// image into instruction memory and releases the core once the checksum matches.
module uart_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  cpu_reset_o,
    output logic                  load_done_o,
    output logic                  load_err_o
);

    localparam int          CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam logic [16:0] MAX_WORDS    = 17'(2 ** ADDR_WIDTH);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx_i),
        .byte_o      (w_byte),
        .byte_valid_o(w_byte_valid),
        .frame_err_o (w_frame_err)
    );

    proto_state_t          r_state;
    proto_state_t          w_state_next;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [7:0]            r_csum;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic [1:0]            r_lane;
    logic [23:0]           r_asm;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_cpu_reset;
    logic                  r_done;
    logic                  r_err;
    logic [15:0]           w_len_rx;
    logic                  w_last_word;

    assign w_len_rx    = {w_byte, r_len_lo};
    // One extra index bit lets LEN == MAX_WORDS finish without wrapping.
    assign w_last_word = ((16'(r_word_idx) + 16'd1) == r_len);

    always_comb begin
        w_state_next = r_state;
        if (w_frame_err && r_state != P_DONE) begin
            w_state_next = P_ERROR;
        end else if (w_byte_valid) begin
            case (r_state)
                P_WAIT_SYNC, P_ERROR: if (w_byte == SYNC_BYTE) w_state_next = P_LEN_LO;
                P_LEN_LO: w_state_next = P_LEN_HI;
                P_LEN_HI: begin
                    if ({1'b0, w_len_rx} > MAX_WORDS) w_state_next = P_ERROR;
                    else if (w_len_rx == 16'd0)       w_state_next = P_CSUM;
                    else                              w_state_next = P_DATA;
                end
                P_DATA:  if (r_lane == 2'd3 && w_last_word) w_state_next = P_CSUM;
                P_CSUM:  w_state_next = (w_byte == r_csum) ? P_DONE : P_ERROR;
                P_DONE:  w_state_next = P_DONE;
                default: w_state_next = P_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= P_WAIT_SYNC;
            r_len_lo    <= '0;
            r_len       <= '0;
            r_csum      <= '0;
            r_word_idx  <= '0;
            r_lane      <= '0;
            r_asm       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mem_we    <= 1'b0;
            r_cpu_reset <= (w_state_next != P_DONE);
            r_done      <= (w_state_next == P_DONE);
            r_err       <= (w_state_next == P_ERROR);

            if (w_byte_valid) begin
                case (r_state)
                    P_WAIT_SYNC, P_ERROR: begin
                        if (w_byte == SYNC_BYTE) begin
                            r_csum     <= '0;
                            r_word_idx <= '0;
                            r_lane     <= '0;
                        end
                    end
                    P_LEN_LO: begin
                        r_len_lo <= w_byte;
                        r_csum   <= r_csum ^ w_byte;
                    end
                    P_LEN_HI: begin
                        r_len  <= w_len_rx;
                        r_csum <= r_csum ^ w_byte;
                    end
                    P_DATA: begin
                        r_csum <= r_csum ^ w_byte;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_asm[7:0]   <= w_byte;
                            2'd1: r_asm[15:8]  <= w_byte;
                            2'd2: r_asm[23:16] <= w_byte;
                            default: begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                                r_mem_wdata <= {w_byte, r_asm};
                                r_word_idx  <= r_word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign cpu_reset_o = r_cpu_reset;
    assign load_done_o = r_done;
    assign load_err_o  = r_err;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a frame-parsing reference model predicts
// memory writes and final status; a monitor checks every write strobe.
module tb_uart_boot_loader;

    localparam int CLK_FREQ_HZ = 1_000_000;
    localparam int BAUD        = 125_000;
    localparam int ADDR_WIDTH  = 9;
    localparam int CPB         = CLK_FREQ_HZ / BAUD;
    localparam int MAX_WORDS   = 2 ** ADDR_WIDTH;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } wr_t;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b1;
    logic                  rx_i  = 1'b1;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o;
    logic                  cpu_reset_o;
    logic                  load_done_o;
    logic                  load_err_o;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         n_pushed = 0;
    int         m_status = 0;   // 0 busy/idle, 1 done, 2 error
    wr_t        exp_q[$];
    wr_t        m_writes[$];
    logic [7:0] stream[$];
    logic [7:0] tx_q[$];
    logic [31:0] w_q[$];
    logic [7:0] hold_q[$];

    uart_boot_loader #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_i       (rx_i),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .cpu_reset_o(cpu_reset_o),
        .load_done_o(load_done_o),
        .load_err_o (load_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: parses the whole byte stream since reset into frames.
    task automatic run_model();
        int i, n, hdr;
        logic [15:0] len;
        logic [7:0]  x;
        bit          partial;
        wr_t         e;
        m_writes.delete();
        m_status = 0;
        i = 0;
        n = stream.size();
        while (i < n && m_status != 1) begin
            if (stream[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            m_status = 0;
            if (i + 2 > n) break;
            hdr = i;
            len = {stream[i+1], stream[i]};
            i += 2;
            if (int'(len) > MAX_WORDS) begin
                m_status = 2;
                continue;
            end
            partial = 0;
            for (int w = 0; w < int'(len); w++) begin
                if (i + 4 > n) begin
                    partial = 1;
                    break;
                end
                e.addr = ADDR_WIDTH'(w);
                e.data = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
                m_writes.push_back(e);
                i += 4;
            end
            if (partial || i >= n) break;
            x = 8'h00;
            for (int k = hdr; k < i; k++) x ^= stream[k];
            m_status = (stream[i] == x) ? 1 : 2;
            i++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_i = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b1;
    endtask

    // Builds a frame from w_q; the checksum is the XOR of length and data bytes.
    task automatic add_frame(input bit bad_csum);
        logic [15:0] len;
        logic [7:0]  x;
        len = 16'(w_q.size());
        tx_q.push_back(8'hA5);
        tx_q.push_back(len[7:0]);
        tx_q.push_back(len[15:8]);
        x = len[7:0] ^ len[15:8];
        foreach (w_q[j]) begin
            for (int k = 0; k < 4; k++) begin
                tx_q.push_back(w_q[j][8*k +: 8]);
                x ^= w_q[j][8*k +: 8];
            end
        end
        tx_q.push_back(bad_csum ? ~x : x);
        w_q.delete();
    endtask

    task automatic run_stream(input string tag);
        foreach (tx_q[k]) stream.push_back(tx_q[k]);
        run_model();
        for (int k = n_pushed; k < m_writes.size(); k++) exp_q.push_back(m_writes[k]);
        n_pushed = m_writes.size();
        foreach (tx_q[k]) begin
            send_byte(tx_q[k], 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        tx_q.delete();
        repeat (6) @(negedge clk);
        check({tag, "_done"},      32'(load_done_o), 32'(m_status == 1));
        check({tag, "_err"},       32'(load_err_o),  32'(m_status == 2));
        check({tag, "_cpu_reset"}, 32'(cpu_reset_o), 32'(m_status != 1));
        check({tag, "_pending"},   32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_pending",   32'(exp_q.size()), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("rst_we",        32'(mem_we_o),    32'd0);
        check("rst_addr",      32'(mem_addr_o),  32'd0);
        check("rst_wdata",     mem_wdata_o,      32'd0);
        check("rst_done",      32'(load_done_o), 32'd0);
        check("rst_err",       32'(load_err_o),  32'd0);
        reset = 1'b0;
        exp_q.delete();
        stream.delete();
        n_pushed = 0;
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset && mem_we_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%08h, expected no write",
                             mem_addr_o, mem_wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr_o), 32'(e.addr));
                    check("wr_data", mem_wdata_o, e.data);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        // Idle line after reset.
        do_reset();
        repeat (2000) @(negedge clk);
        check("idle_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("idle_done",      32'(load_done_o), 32'd0);
        check("idle_err",       32'(load_err_o),  32'd0);

        // Two-word program, then a frame that DONE must ignore.
        do_reset();
        w_q = '{32'h0000_0013, 32'h0010_0093};
        add_frame(0);
        run_stream("two_word");
        w_q = '{32'hCAFE_F00D};
        add_frame(0);
        run_stream("after_done");

        // Leading garbage before the sync byte.
        do_reset();
        tx_q = '{8'h55, 8'h00};
        w_q  = '{32'h1234_5678};
        add_frame(0);
        run_stream("garbage_lead");

        // Bad checksum, then recovery with a good frame.
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        run_stream("bad_csum");
        w_q = '{32'h1234_5678};
        add_frame(0);
        run_stream("recover");

        // Oversize length.
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h02};
        run_stream("len_513");

        // LEN == MAX_WORDS is accepted; a framing error mid-data forces ERROR.
        do_reset();
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_stream("len_max");
        send_byte(8'h3C, 1'b0);
        repeat (6) @(negedge clk);
        check("ferr_err",       32'(load_err_o),  32'd1);
        check("ferr_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("ferr_done",      32'(load_done_o), 32'd0);

        // Start-bit glitch in the middle of a word must not add a byte.
        do_reset();
        w_q = '{32'h4433_2211};
        add_frame(0);
        hold_q = tx_q[5:$];
        tx_q   = tx_q[0:4];
        run_stream("pre_glitch");
        @(negedge clk);
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (20) @(negedge clk);
        tx_q = hold_q;
        run_stream("post_glitch");

        // Reset mid-frame discards progress; the next frame starts clean.
        do_reset();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        run_stream("mid_frame");
        do_reset();
        w_q = '{32'h0BAD_BEEF};
        add_frame(0);
        run_stream("after_reset");

        // Randomized frames with optional garbage and corrupted checksums.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                tx_q.push_back(b);
            end
            repeat ($urandom_range(0, 5)) w_q.push_back($urandom);
            add_frame($urandom_range(0, 3) == 0);
            run_stream("rand");
        end

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
